// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: FSM states, widths and the GF(2^8) xtime helper.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MIX,
        DONE
    } state_e;

    localparam int unsigned COL_W   = 32;
    localparam int unsigned STATE_W = 128;
    localparam int unsigned N_COLS  = 4;
    localparam logic [7:0]  XTIME_POLY = 8'h1B;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/MixColumns_calculation.sv
// Combinational AES MixColumns for a single 32-bit column; byte 0 is the column MSB.
module MixColumns_calculation
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] col,
    output logic [COL_W-1:0] col_out
);

    logic [7:0] b0, b1, b2, b3;
    logic [7:0] x0, x1, x2, x3;

    always_comb begin
        b0 = col[31:24];
        b1 = col[23:16];
        b2 = col[15:8];
        b3 = col[7:0];
        x0 = xtime(b0);
        x1 = xtime(b1);
        x2 = xtime(b2);
        x3 = xtime(b3);
        // 3*b is xtime(b) ^ b
        col_out[31:24] = x0 ^ (x1 ^ b1) ^ b2 ^ b3;
        col_out[23:16] = b0 ^ x1 ^ (x2 ^ b2) ^ b3;
        col_out[15:8]  = b0 ^ b1 ^ x2 ^ (x3 ^ b3);
        col_out[7:0]   = (x0 ^ b0) ^ b1 ^ b2 ^ x3;
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential MixColumns: one shared column unit processes the four columns over four cycles,
// with a valid/ready handshake on both sides and an optional final-round bypass.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    input  logic               in_skip,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    output logic               busy
);

    localparam int unsigned IDX_W = $clog2(N_COLS);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   col_idx_q, col_idx_d;
    logic [STATE_W-1:0] data_q, data_d;
    logic [COL_W-1:0]   col_in, col_mixed;
    logic               accept;

    always_comb begin
        case (col_idx_q)
            2'd0:    col_in = data_q[127:96];
            2'd1:    col_in = data_q[95:64];
            2'd2:    col_in = data_q[63:32];
            default: col_in = data_q[31:0];
        endcase
    end

    MixColumns_calculation u_mix (
        .col     (col_in),
        .col_out (col_mixed)
    );

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        data_d    = data_q;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
        accept = in_valid && in_ready;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE && out_ready) begin
                    state_d = IDLE;
                end
                // A DONE handoff and a new accept can share the same edge
                if (accept) begin
                    data_d    = in_data;
                    col_idx_d = '0;
                    state_d   = (in_skip && BYPASS_EN) ? DONE : MIX;
                end
            end
            MIX: begin
                case (col_idx_q)
                    2'd0:    data_d[127:96] = col_mixed;
                    2'd1:    data_d[95:64]  = col_mixed;
                    2'd2:    data_d[63:32]  = col_mixed;
                    default: data_d[31:0]   = col_mixed;
                endcase
                col_idx_d = col_idx_q + 1'b1;
                if (col_idx_q == IDX_W'(N_COLS - 1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            col_idx_q <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            data_q    <= data_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;

endmodule

// File: doc/mix_columns_seq.md
MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 SHALL provide parameter BYPASS_EN, default 1, meaning 1 honours in_skip and 0 ignores in_skip (always mix).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream presents a 128-bit state.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-006 SHALL have port in_data, input, 128 bits: AES state; column 0 = [127:96], column 3 = [31:0].
REQ-007 SHALL have port in_skip, input, 1 bit: final-round flag; pass state through unmixed.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds a finished result.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream consumes out_data.
REQ-010 SHALL have port out_data, output, 128 bits: mixed (or bypassed) state.
REQ-011 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-012 SHALL time-share one 32-bit column-mix unit across the four columns, one column per cycle.
REQ-013 SHALL implement FSM states IDLE, MIX, DONE.
REQ-014 in_ready SHALL be 1 in IDLE, equal out_ready in DONE, and be 0 in MIX.
REQ-015 Accept (in_valid && in_ready) SHALL load in_data into the 128-bit state register, clear col_idx to 0, and go to MIX, or to DONE if in_skip && BYPASS_EN.
REQ-016 In MIX, each cycle SHALL replace column col_idx of the state register with its mixed value and increment col_idx (2-bit).
REQ-017 When col_idx==3 in MIX, SHALL write column 3 and go to DONE; col_idx wraps to 0.
REQ-018 Latency SHALL be: out_valid rises 5 edges after the accept edge when mixing, and 1 edge after when bypassing.
REQ-019 out_valid SHALL be 1 exactly in DONE; out_data SHALL equal the state register and stay stable while out_valid && !out_ready.
REQ-020 DONE with out_ready && !in_valid SHALL go to IDLE.
REQ-021 DONE with out_ready && in_valid SHALL complete the handoff and accept the new state on the same edge (zero-bubble back-to-back); the new state loads per REQ-015.
REQ-022 in_data and in_skip SHALL be ignored when in_ready=0; in_skip is sampled only on the accept edge.
REQ-023 Column-mix arithmetic SHALL be GF(2^8), polynomial 0x11B, matrix rows [2 3 1 1], [1 2 3 1], [1 1 2 3], [3 1 1 2]; byte 0 is the column MSB.

Reset
REQ-024 rst_n=0 at a clock edge SHALL force IDLE, col_idx=0, state register=0, out_valid=0, busy=0, in_ready=1 after the edge, including mid-MIX or in DONE; a partial result is discarded.
REQ-025 No accept SHALL occur on an edge where rst_n=0.

Structure
REQ-026 Shared package aes_pkg SHALL hold the FSM state enum, column width 32, state width 128, number of columns 4, and xtime polynomial 0x1B.
REQ-027 SHALL instantiate exactly one sub-module, MixColumns_calculation (ports col[31:0] and col_out[31:0]), driven by a col_idx mux.

Verification
REQ-028 Mix vector: in_data=db135345_f20a225c_01010101_c6c6c6c6, in_skip=0, out_ready=1 -> out_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6, with out_valid 5 edges after accept.
REQ-029 Bypass: in_data=d4d4d4d5_2d26314c_00000000_ffffffff, in_skip=1 -> identical out_data after 1 edge; with BYPASS_EN=0 -> d5d5d7d6_4d7ebdf8_00000000_ffffffff after 5 edges.
REQ-030 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_data hold, in_ready=0, busy=1; out_ready=1 -> IDLE next edge.
REQ-031 Back-to-back: in_valid held with 3 vectors and out_ready=1 -> one result every 5 cycles, no lost or duplicated output.
REQ-032 Reset mid-MIX: rst_n=0 at col_idx=2 -> next cycle IDLE, out_valid=0, out_data=0; a fresh vector then produces the correct result.
